// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: round count limit, FSM states, round index type and
// the round-constant helper used by the permutation controller.
package ascon_pkg;

    localparam int ASCON_MAX_ROUNDS = 12;

    typedef logic [3:0] round_idx_t;

    localparam round_idx_t ASCON_LAST_IDX = 4'd11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } perm_state_e;

    // Round constant: upper nibble counts down while the lower nibble counts up.
    function automatic logic [7:0] ascon_rc(round_idx_t idx);
        return {4'hF - idx, idx};
    endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Handshake and datapath-control bundle between the mode FSM (master), the
// permutation controller (slave) and the permutation datapath.
// abort_i exists only when ASCON_PERM_ABORT_EN is defined.
interface ascon_perm_ctrl_if;

    logic       start_valid_i;
    logic       start_ready_o;
    logic       mode_i;
    logic       state_load_o;
    logic       round_en_o;
    logic [3:0] round_idx_o;
    logic [7:0] rc_o;
    logic       last_round_o;
    logic       done_valid_o;
    logic       done_ready_i;
    logic       busy_o;
`ifdef ASCON_PERM_ABORT_EN
    logic       abort_i;
`endif

    modport master (
        output start_valid_i, mode_i, done_ready_i,
`ifdef ASCON_PERM_ABORT_EN
        output abort_i,
`endif
        input  start_ready_o, state_load_o, round_en_o, round_idx_o, rc_o,
        input  last_round_o, done_valid_o, busy_o
    );

    modport slave (
        input  start_valid_i, mode_i, done_ready_i,
`ifdef ASCON_PERM_ABORT_EN
        input  abort_i,
`endif
        output start_ready_o, state_load_o, round_en_o, round_idx_o, rc_o,
        output last_round_o, done_valid_o, busy_o
    );

endinterface

// File: rtl/ascon_rc_gen.sv
// Round index counter with round-constant and last-round registers.
// The index is loaded with its start value on accept, steps once per RUN cycle
// and saturates at the final round index.
module ascon_rc_gen
    import ascon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_load,
    input  round_idx_t i_start_idx,
    input  logic       i_inc,
    input  logic       i_en_next,
    output round_idx_t o_idx,
    output logic [7:0] o_rc,
    output logic       o_last
);

    round_idx_t r_idx;
    logic [7:0] r_rc;
    logic       r_last;
    round_idx_t w_idx_next;

    // Next index: load wins over increment; never step past the last round.
    always_comb begin
        w_idx_next = r_idx;
        if (i_load) begin
            w_idx_next = i_start_idx;
        end else if (i_inc && (r_idx != ASCON_LAST_IDX)) begin
            w_idx_next = r_idx + 4'd1;
        end
    end

    // Index, constant and last flag are registered together so they line up with round_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_rc   <= '0;
            r_last <= 1'b0;
        end else begin
            r_idx  <= w_idx_next;
            r_rc   <= ascon_rc(w_idx_next);
            r_last <= i_en_next && (w_idx_next == ASCON_LAST_IDX);
        end
    end

    assign o_idx  = r_idx;
    assign o_rc   = r_rc;
    assign o_last = r_last;

endmodule

// File: rtl/ascon_perm_ctrl.sv
// ASCON permutation round sequencer: IDLE -> LOAD -> RUN -> DONE.
// Optional build macro ASCON_PERM_ABORT_EN adds abort_i, which returns any
// busy state to IDLE on the next edge without signalling completion.
module ascon_perm_ctrl
    import ascon_pkg::*;
#(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input logic            clk,
    input logic            rst,
    ascon_perm_ctrl_if.slave bus
);

    if ((ROUNDS_A < 1) || (ROUNDS_A > ASCON_MAX_ROUNDS)) begin : g_bad_rounds_a
        $error("ascon_perm_ctrl: ROUNDS_A must be in 1..12");
    end
    if ((ROUNDS_B < 1) || (ROUNDS_B > ROUNDS_A)) begin : g_bad_rounds_b
        $error("ascon_perm_ctrl: ROUNDS_B must be in 1..ROUNDS_A");
    end

    localparam round_idx_t START_A = round_idx_t'(ASCON_MAX_ROUNDS - ROUNDS_A);
    localparam round_idx_t START_B = round_idx_t'(ASCON_MAX_ROUNDS - ROUNDS_B);

    perm_state_e r_state;
    logic        r_load;
    logic        r_en;
    logic        r_done;
    logic        r_busy;

    logic        w_abort;
    logic        w_ready;
    logic        w_accept;
    logic        w_en_next;
    round_idx_t  w_start_idx;
    round_idx_t  w_idx;
    logic [7:0]  w_rc;
    logic        w_last;

`ifdef ASCON_PERM_ABORT_EN
    assign w_abort = bus.abort_i && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Ready follows done_ready in DONE so a new request can chain onto the handshake.
    assign w_ready     = (r_state == IDLE) || ((r_state == DONE) && bus.done_ready_i);
    assign w_accept    = bus.start_valid_i && w_ready && !w_abort;
    assign w_start_idx = bus.mode_i ? START_B : START_A;
    assign w_en_next   = !w_abort &&
                         ((r_state == LOAD) || ((r_state == RUN) && (w_idx != ASCON_LAST_IDX)));

    ascon_rc_gen u_rc_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_accept),
        .i_start_idx (w_start_idx),
        .i_inc       ((r_state == RUN) && !w_abort),
        .i_en_next   (w_en_next),
        .o_idx       (w_idx),
        .o_rc        (w_rc),
        .o_last      (w_last)
    );

    // Sequencing FSM with registered strobes; abort and reset both drop to IDLE silently.
    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_state <= IDLE;
            r_load  <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    r_state <= RUN;
                    r_en    <= 1'b1;
                end
                RUN: begin
                    if (w_idx == ASCON_LAST_IDX) begin
                        r_state <= DONE;
                        r_en    <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.done_ready_i) begin
                        r_done <= 1'b0;
                        if (bus.start_valid_i) begin
                            r_state <= LOAD;
                            r_load  <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready_o = w_ready;
    assign bus.state_load_o  = r_load;
    assign bus.round_en_o    = r_en;
    assign bus.round_idx_o   = w_idx;
    assign bus.rc_o          = w_rc;
    assign bus.last_round_o  = w_last;
    assign bus.done_valid_o  = r_done;
    assign bus.busy_o        = r_busy;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: table of permutation requests plus
// hand-written back-to-back, reset-in-RUN and (with ASCON_PERM_ABORT_EN) abort sequences.
module tb_ascon_perm_ctrl;

    typedef struct {
        logic             mode;
        int               rounds;
        logic [11:0][7:0] rc;
        int               stall;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    ascon_perm_ctrl_if u_if ();

    ascon_perm_ctrl #(
        .ROUNDS_A (12),
        .ROUNDS_B (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    localparam logic [11:0][7:0] RC_A = {8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
                                         8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
    localparam logic [11:0][7:0] RC_B = {48'h0, 8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96};

    txn_t txns [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " ready"}, 32'(u_if.start_ready_o), 32'd1);
        chk({tag, " busy"},  32'(u_if.busy_o),        32'd0);
        chk({tag, " done"},  32'(u_if.done_valid_o),  32'd0);
        chk({tag, " en"},    32'(u_if.round_en_o),    32'd0);
        chk({tag, " load"},  32'(u_if.state_load_o),  32'd0);
    endtask

    // From the load cycle: check the load strobe, every round, and arrival in DONE.
    task automatic run_rounds(input txn_t t, input string tag);
        chk({tag, " load"},  32'(u_if.state_load_o), 32'd1);
        chk({tag, " ld_en"}, 32'(u_if.round_en_o),   32'd0);
        chk({tag, " busy"},  32'(u_if.busy_o),       32'd1);
        chk({tag, " ld_rdy"},32'(u_if.start_ready_o),32'd0);
        step();
        for (int r = 0; r < t.rounds; r++) begin
            chk({tag, " en"},   32'(u_if.round_en_o),   32'd1);
            chk({tag, " idx"},  32'(u_if.round_idx_o),  32'(12 - t.rounds + r));
            chk({tag, " rc"},   32'(u_if.rc_o),         32'(t.rc[r]));
            chk({tag, " last"}, 32'(u_if.last_round_o), 32'(r == t.rounds - 1));
            chk({tag, " rdone"},32'(u_if.done_valid_o), 32'd0);
            chk({tag, " rload"},32'(u_if.state_load_o), 32'd0);
            step();
        end
        chk({tag, " done"},   32'(u_if.done_valid_o), 32'd1);
        chk({tag, " d_en"},   32'(u_if.round_en_o),   32'd0);
        chk({tag, " d_last"}, 32'(u_if.last_round_o), 32'd0);
    endtask

    // Hold done_ready low for t.stall cycles (with a competing request), then release.
    task automatic finish_txn(input txn_t t, input string tag);
        for (int s = 0; s < t.stall; s++) begin
            u_if.done_ready_i  = 1'b0;
            u_if.start_valid_i = 1'b1;
            #1;
            chk({tag, " st_rdy"},  32'(u_if.start_ready_o), 32'd0);
            chk({tag, " st_done"}, 32'(u_if.done_valid_o),  32'd1);
            chk({tag, " st_en"},   32'(u_if.round_en_o),    32'd0);
            chk({tag, " st_idx"},  32'(u_if.round_idx_o),   32'd11);
            step();
        end
        u_if.start_valid_i = 1'b0;
        u_if.done_ready_i  = 1'b1;
        #1;
        chk({tag, " rel_rdy"}, 32'(u_if.start_ready_o), 32'd1);
        step();
        u_if.done_ready_i = 1'b0;
        chk_idle({tag, " post"});
    endtask

    task automatic issue(input logic mode);
        u_if.start_valid_i = 1'b1;
        u_if.mode_i        = mode;
        step();
        u_if.start_valid_i = 1'b0;
        u_if.mode_i        = ~mode;
    endtask

    initial begin
        txn_t tb2;
        u_if.start_valid_i = 1'b0;
        u_if.mode_i        = 1'b0;
        u_if.done_ready_i  = 1'b0;
`ifdef ASCON_PERM_ABORT_EN
        u_if.abort_i       = 1'b0;
`endif
        txns[0] = '{1'b0, 12, RC_A, 0};
        txns[1] = '{1'b1, 6,  RC_B, 0};
        txns[2] = '{1'b1, 6,  RC_B, 5};
        txns[3] = '{1'b0, 12, RC_A, 2};

        @(negedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset idx",  32'(u_if.round_idx_o),  32'd0);
        chk("reset rc",   32'(u_if.rc_o),         32'd0);
        chk("reset last", 32'(u_if.last_round_o), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) begin
            chk_idle($sformatf("t%0d pre", i));
            issue(txns[i].mode);
            run_rounds(txns[i], $sformatf("t%0d", i));
            finish_txn(txns[i], $sformatf("t%0d", i));
        end

        // Back-to-back: done handshake and p^b request in the same cycle.
        issue(1'b0);
        run_rounds(txns[0], "b2b_a");
        u_if.done_ready_i  = 1'b1;
        u_if.start_valid_i = 1'b1;
        u_if.mode_i        = 1'b1;
        #1;
        chk("b2b ready", 32'(u_if.start_ready_o), 32'd1);
        step();
        u_if.done_ready_i  = 1'b0;
        u_if.start_valid_i = 1'b0;
        u_if.mode_i        = 1'b0;
        run_rounds(txns[1], "b2b_b");
        finish_txn(txns[1], "b2b_b");

        // Synchronous reset in RUN at idx 8, then a clean p^a run.
        issue(1'b0);
        step();
        for (int r = 0; r < 8; r++) step();
        chk("rst pre idx", 32'(u_if.round_idx_o), 32'd8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst");
        chk("rst idx", 32'(u_if.round_idx_o), 32'd0);
        chk("rst rc",  32'(u_if.rc_o),        32'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rst nodone", 32'(u_if.done_valid_o), 32'd0);
        end
        issue(1'b0);
        run_rounds(txns[0], "rst_a");
        finish_txn(txns[0], "rst_a");

`ifdef ASCON_PERM_ABORT_EN
        // Abort in RUN at idx 3: back to IDLE on the next edge with no done.
        issue(1'b0);
        step();
        for (int r = 0; r < 3; r++) step();
        chk("abort pre idx", 32'(u_if.round_idx_o), 32'd3);
        u_if.abort_i = 1'b1;
        step();
        u_if.abort_i = 1'b0;
        chk_idle("abort");
        for (int c = 0; c < 10; c++) begin
            step();
            chk("abort nodone", 32'(u_if.done_valid_o), 32'd0);
        end
        tb2 = txns[1];
        issue(1'b1);
        run_rounds(tb2, "abort_b");
        finish_txn(tb2, "abort_b");
`else
        tb2 = txns[1];
        issue(1'b1);
        run_rounds(tb2, "tail_b");
        finish_txn(tb2, "tail_b");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
